// File: rtl/display7_scan.sv
// Time-multiplexed common-anode seven-segment scanner with shadow/display frame buffers.
// Define DISPLAY7_SCAN_HEX_EN to decode nibbles 10-15 as hex glyphs instead of blanking them.
module display7_scan #(
    parameter int DIGITS  = 8,
    parameter int CLK_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   iData,
    input  logic [DIGITS-1:0]     iDp,
    input  logic [DIGITS-1:0]     iMask,
    input  logic                  iLzb,
    input  logic                  iLoad,
    output logic [6:0]            oSeg,
    output logic                  oDp,
    output logic [DIGITS-1:0]     oAn
);

    localparam int SW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [SW-1:0] SLOT_LAST  = SW'(CLK_DIV - 1);
    localparam logic [IW-1:0] DIGIT_LAST = IW'(DIGITS - 1);

    logic [SW-1:0]        slotCnt;
    logic [IW-1:0]        digitIdx;
    logic [4*DIGITS-1:0]  shadowData;
    logic [DIGITS-1:0]    shadowDp;
    logic [4*DIGITS-1:0]  dispData;
    logic [DIGITS-1:0]    dispDp;

    logic                 slotWrap;
    logic                 frameEnd;
    logic [3:0]           curNib;
    logic                 curDp;
    logic                 curMask;
    logic                 curBlank;
    logic                 allZero;
    logic [DIGITS-1:0]    anSel;
    logic [6:0]           segNext;
    logic                 dpNext;
    logic [DIGITS-1:0]    anNext;

    // Active-low glyphs, bit 0 = segment a.
    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] seg;
        seg = 7'h7F;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
`ifdef DISPLAY7_SCAN_HEX_EN
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
`endif
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    assign slotWrap = (slotCnt == SLOT_LAST);
    assign frameEnd = slotWrap && (digitIdx == DIGIT_LAST);

    // Walk from the most significant digit down so the zero run above each digit is known.
    always_comb begin
        curNib   = 4'h0;
        curDp    = 1'b0;
        curMask  = 1'b0;
        curBlank = 1'b0;
        allZero  = 1'b1;
        anSel    = '1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            allZero = allZero && (dispData[4*k +: 4] == 4'h0);
            if (digitIdx == IW'(k)) begin
                curNib   = dispData[4*k +: 4];
                curDp    = dispDp[k];
                curMask  = iMask[k];
                curBlank = iLzb && allZero && (k != 0);
                anSel[k] = 1'b0;
            end
        end
    end

    always_comb begin
        segNext = 7'h7F;
        dpNext  = 1'b1;
        anNext  = '1;
        if ((slotCnt != '0) && curMask && !curBlank) begin
            segNext = decode(curNib);
            dpNext  = ~curDp;
            anNext  = anSel;
        end
    end

    // A load on the frame-boundary edge bypasses the shadow so it shows in the frame that starts.
    always_ff @(posedge clk) begin
        if (reset) begin
            slotCnt    <= '0;
            digitIdx   <= '0;
            shadowData <= '0;
            shadowDp   <= '0;
            dispData   <= '0;
            dispDp     <= '0;
            oSeg       <= 7'h7F;
            oDp        <= 1'b1;
            oAn        <= '1;
        end else begin
            slotCnt <= slotWrap ? '0 : slotCnt + SW'(1);
            if (slotWrap) begin
                digitIdx <= (digitIdx == DIGIT_LAST) ? '0 : digitIdx + IW'(1);
            end
            if (iLoad) begin
                shadowData <= iData;
                shadowDp   <= iDp;
            end
            if (frameEnd) begin
                dispData <= iLoad ? iData : shadowData;
                dispDp   <= iLoad ? iDp   : shadowDp;
            end
            oSeg <= segNext;
            oDp  <= dpNext;
            oAn  <= anNext;
        end
    end

endmodule

// File: tb/tb_display7_scan.sv
// Scoreboard bench for display7_scan (DIGITS=4, CLK_DIV=4); honours DISPLAY7_SCAN_HEX_EN.
module tb_display7_scan;

    localparam int DIGITS  = 4;
    localparam int CLK_DIV = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] iData;
    logic [3:0]  iDp;
    logic [3:0]  iMask;
    logic        iLzb;
    logic        iLoad;
    logic [6:0]  oSeg;
    logic        oDp;
    logic [3:0]  oAn;

    int checks = 0;
    int errors = 0;

    logic [11:0] expQ[$];
    string       nameQ[$];

    int          mSlot;
    int          mDig;
    logic [15:0] mShadow;
    logic [15:0] mDisp;
    logic [3:0]  mShDp;
    logic [3:0]  mDispDp;

    always #5 clk = ~clk;

    display7_scan #(.DIGITS(DIGITS), .CLK_DIV(CLK_DIV)) dut (
        .clk   (clk),
        .reset (reset),
        .iData (iData),
        .iDp   (iDp),
        .iMask (iMask),
        .iLzb  (iLzb),
        .iLoad (iLoad),
        .oSeg  (oSeg),
        .oDp   (oDp),
        .oAn   (oAn)
    );

    // Hand-derived active-low glyph codes.
    function automatic logic [6:0] glyph(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0: g = 7'h40;
            4'h1: g = 7'h79;
            4'h2: g = 7'h24;
            4'h3: g = 7'h30;
            4'h4: g = 7'h19;
            4'h5: g = 7'h12;
            4'h6: g = 7'h02;
            4'h7: g = 7'h78;
            4'h8: g = 7'h00;
            4'h9: g = 7'h10;
`ifdef DISPLAY7_SCAN_HEX_EN
            4'hA: g = 7'h08;
            4'hB: g = 7'h03;
            4'hC: g = 7'h46;
            4'hD: g = 7'h21;
            4'hE: g = 7'h06;
            4'hF: g = 7'h0E;
`endif
            default: g = 7'h7F;
        endcase
        return g;
    endfunction

    // One clock: queue the output expected after the coming edge, then advance the model.
    task automatic applyStimulus(input string tag);
        logic [11:0] e;
        logic [3:0]  nib;
        logic        blank;
        e = {7'h7F, 1'b1, 4'hF};
        if (reset) begin
            mSlot   = 0;
            mDig    = 0;
            mShadow = '0;
            mDisp   = '0;
            mShDp   = '0;
            mDispDp = '0;
        end else begin
            if (mSlot != 0) begin
                nib   = mDisp[mDig*4 +: 4];
                blank = !iMask[mDig];
                if (iLzb && mDig > 0 && (mDisp >> (mDig*4)) == 16'h0) blank = 1'b1;
                if (!blank) e = {glyph(nib), ~mDispDp[mDig], ~(4'b0001 << mDig)};
            end
            if (iLoad) begin
                mShadow = iData;
                mShDp   = iDp;
            end
            if (mSlot == CLK_DIV - 1 && mDig == DIGITS - 1) begin
                mDisp   = mShadow;
                mDispDp = mShDp;
            end
            if (mSlot == CLK_DIV - 1) begin
                mSlot = 0;
                mDig  = (mDig == DIGITS - 1) ? 0 : mDig + 1;
            end else begin
                mSlot = mSlot + 1;
            end
        end
        expQ.push_back(e);
        nameQ.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic runCycles(input int n, input string tag);
        for (int i = 0; i < n; i++) applyStimulus(tag);
    endtask

    task automatic runToBoundary(input string tag);
        while (!(mSlot == CLK_DIV - 1 && mDig == DIGITS - 1)) applyStimulus(tag);
    endtask

    task automatic loadPulse(input logic [15:0] d, input logic [3:0] dp, input string tag);
        iData = d;
        iDp   = dp;
        iLoad = 1'b1;
        applyStimulus(tag);
        iLoad = 1'b0;
    endtask

    // Monitor: the DUT presents a fresh registered output every cycle.
    task automatic checkOutput();
        logic [11:0] e;
        string       tag;
        e   = expQ.pop_front();
        tag = nameQ.pop_front();
        checks++;
        if ({oSeg, oDp, oAn} !== e) begin
            errors++;
            $display("[TB] FAIL %s @%0t: got seg=%h dp=%b an=%b, expected seg=%h dp=%b an=%b",
                     tag, $time, oSeg, oDp, oAn, e[11:5], e[4], e[3:0]);
        end
    endtask

    always @(negedge clk) begin
        if (expQ.size() > 0) checkOutput();
    end

    initial begin
        reset = 1'b1;
        iData = '0;
        iDp   = '0;
        iMask = 4'hF;
        iLzb  = 1'b0;
        iLoad = 1'b0;
        mSlot = 0;
        mDig  = 0;

        runCycles(3, "reset");
        reset = 1'b0;
        runCycles(2, "firstScan");
        runToBoundary("frameZero");
        runCycles(1, "frameZeroEdge");

        runCycles(2, "preLoad");
        loadPulse(16'h1234, 4'b0100, "load1234");
        runToBoundary("oldFrame");
        runCycles(1 + DIGITS*CLK_DIV, "scan1234");

        runCycles(5, "tearHead");
        loadPulse(16'h5678, 4'b0000, "tearLoad");
        runToBoundary("tearRest");
        runCycles(1 + DIGITS*CLK_DIV, "scan5678");

        iLzb = 1'b1;
        loadPulse(16'h0005, 4'b0000, "lzbLoad5");
        runToBoundary("lzbWait5");
        runCycles(1 + DIGITS*CLK_DIV, "lzb0005");
        loadPulse(16'h0000, 4'b0000, "lzbLoad0");
        runToBoundary("lzbWait0");
        runCycles(1 + DIGITS*CLK_DIV, "lzb0000");

        iLzb  = 1'b0;
        iMask = 4'b1011;
        runCycles(DIGITS*CLK_DIV, "mask");
        runToBoundary("maskWait");
        loadPulse(16'h4321, 4'b1000, "edgeLoad");
        runCycles(DIGITS*CLK_DIV, "edgeFrame");

        iMask = 4'hF;
        loadPulse(16'h000A, 4'b0001, "hexLoad");
        runToBoundary("hexWait");
        runCycles(1 + DIGITS*CLK_DIV, "nibbleA");

        runCycles(3, "preReset");
        loadPulse(16'h8888, 4'b1111, "pendingLoad");
        runCycles(2, "pendingHold");
        reset = 1'b1;
        runCycles(1, "midReset");
        reset = 1'b0;
        runCycles(2 + 2*DIGITS*CLK_DIV, "postReset");

        repeat (3) @(negedge clk);
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d pending entries, expected 0", expQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
